// File: rtl/regfile_param.sv
// regfile_param: clocked register file with two registered read ports,
// write-first bypass and a walking bulk-clear engine.
module regfile_param #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [WIDTH-1:0]  WriteValue,
    output logic              WriteAck,
    input  logic              ReadEnable1,
    input  logic [ADDR_W-1:0] ReadAddress1,
    output logic [WIDTH-1:0]  ReadValue1,
    output logic              ReadValid1,
    input  logic              ReadEnable2,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic [WIDTH-1:0]  ReadValue2,
    output logic              ReadValid2,
    input  logic              Clear,
    output logic              ClearBusy
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_rv1, r_rv2;
    logic              r_vld1, r_vld2;
    logic              w_clr_we;
    logic [WIDTH-1:0]  w_rd1, w_rd2;

    // Addresses that never map to writable storage read as zero.
    function automatic logic f_void(input logic [ADDR_W-1:0] a);
        return (32'(a) >= 32'(DEPTH)) || (ZERO_REG && a == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == IDLE) begin
            if (Clear) begin
                w_state_nxt = CLEAR;
                w_cnt_nxt   = '0;
            end
        end else if (r_cnt == LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
    end

    always_comb begin
        w_clr_we  = r_state == CLEAR;
        ClearBusy = r_state == CLEAR;
        WriteAck  = WriteEnable && r_state == IDLE && !Clear && !f_void(WriteAddress);
    end

    // Write-first: a same-edge commit (host or clear engine) is what the reader sees.
    assign w_rd1 = f_void(ReadAddress1) ? '0 :
                   (WriteAck && ReadAddress1 == WriteAddress) ? WriteValue :
                   (w_clr_we && ReadAddress1 == r_cnt) ? '0 : r_mem[ReadAddress1];
    assign w_rd2 = f_void(ReadAddress2) ? '0 :
                   (WriteAck && ReadAddress2 == WriteAddress) ? WriteValue :
                   (w_clr_we && ReadAddress2 == r_cnt) ? '0 : r_mem[ReadAddress2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (WriteAck) begin
            r_mem[WriteAddress] <= WriteValue;
        end else if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rv1  <= '0;
            r_rv2  <= '0;
            r_vld1 <= 1'b0;
            r_vld2 <= 1'b0;
        end else begin
            r_vld1 <= ReadEnable1;
            r_vld2 <= ReadEnable2;
            if (ReadEnable1) r_rv1 <= w_rd1;
            if (ReadEnable2) r_rv2 <= w_rd2;
        end
    end

    assign ReadValue1 = r_rv1;
    assign ReadValue2 = r_rv2;
    assign ReadValid1 = r_vld1;
    assign ReadValid2 = r_vld2;
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: drives a default instance and a DEPTH=24/ZERO_REG=0 instance
// with shared stimulus, checked against a next-state memory model and read queue.
module tb_regfile_param;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        we = 1'b0, clr = 1'b0, re1 = 1'b0, re2 = 1'b0;
    logic [4:0]  wa = '0, ra1 = '0, ra2 = '0;
    logic [31:0] wv = '0;
    logic [1:0]  ack, vld1, vld2, busy;
    logic [31:0] rv1 [2];
    logic [31:0] rv2 [2];
    int          n_cmp = 0, n_err = 0;
    logic [31:0] m_mem [2][32];
    logic        m_busy [2];
    logic [4:0]  m_cnt [2];
    logic        m_v1 [2];
    logic        m_v2 [2];
    logic [31:0] m_l1 [2];
    logic [31:0] m_l2 [2];
    logic [31:0] q [$];

    always #5 clk = ~clk;

    regfile_param u_main (
        .clk(clk), .rst_n(rst_n),
        .WriteEnable(we), .WriteAddress(wa), .WriteValue(wv), .WriteAck(ack[0]),
        .ReadEnable1(re1), .ReadAddress1(ra1), .ReadValue1(rv1[0]), .ReadValid1(vld1[0]),
        .ReadEnable2(re2), .ReadAddress2(ra2), .ReadValue2(rv2[0]), .ReadValid2(vld2[0]),
        .Clear(clr), .ClearBusy(busy[0])
    );

    regfile_param #(.DEPTH(24), .ZERO_REG(1'b0)) u_alt (
        .clk(clk), .rst_n(rst_n),
        .WriteEnable(we), .WriteAddress(wa), .WriteValue(wv), .WriteAck(ack[1]),
        .ReadEnable1(re1), .ReadAddress1(ra1), .ReadValue1(rv1[1]), .ReadValid1(vld1[1]),
        .ReadEnable2(re2), .ReadAddress2(ra2), .ReadValue2(rv2[1]), .ReadValid2(vld2[1]),
        .Clear(clr), .ClearBusy(busy[1])
    );

    function automatic int dep(input int k);
        return (k != 0) ? 24 : 32;
    endfunction

    function automatic bit void_a(input int k, input logic [4:0] a);
        return int'(a) >= dep(k) || (k == 0 && a == 5'd0);
    endfunction

    function automatic bit ack_of(input int k);
        return we && !m_busy[k] && !clr && !void_a(k, wa);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0;
            m_cnt[k]  = '0;
            m_v1[k]   = 1'b0;
            m_v2[k]   = 1'b0;
            m_l1[k]   = '0;
            m_l2[k]   = '0;
            for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
        end
        q.delete();
    endtask

    task automatic chk_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
            chk($sformatf("rst_vld1_%0d", k), 32'(vld1[k]), 32'd0);
            chk($sformatf("rst_vld2_%0d", k), 32'(vld2[k]), 32'd0);
            chk($sformatf("rst_rv1_%0d", k), rv1[k], 32'd0);
            chk($sformatf("rst_rv2_%0d", k), rv2[k], 32'd0);
        end
    endtask

    // One clock: check WriteAck before the edge, advance the model at the edge,
    // then check registered outputs just after it.
    task automatic cyc();
        logic a [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            a[k] = ack_of(k);
            chk($sformatf("ack%0d", k), 32'(ack[k]), 32'(a[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (a[k]) m_mem[k][wa] = wv;
            else if (m_busy[k]) m_mem[k][m_cnt[k]] = '0;
            if (re1) q.push_back(void_a(k, ra1) ? 32'd0 : m_mem[k][ra1]);
            if (re2) q.push_back(void_a(k, ra2) ? 32'd0 : m_mem[k][ra2]);
            m_v1[k] = re1;
            m_v2[k] = re2;
            if (m_busy[k]) begin
                if (m_cnt[k] == 5'(dep(k) - 1)) begin
                    m_busy[k] = 1'b0;
                    m_cnt[k]  = '0;
                end else m_cnt[k]++;
            end else if (clr) begin
                m_busy[k] = 1'b1;
                m_cnt[k]  = '0;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            if (m_v1[k]) m_l1[k] = q.pop_front();
            if (m_v2[k]) m_l2[k] = q.pop_front();
            chk($sformatf("vld1_%0d", k), 32'(vld1[k]), 32'(m_v1[k]));
            chk($sformatf("vld2_%0d", k), 32'(vld2[k]), 32'(m_v2[k]));
            chk($sformatf("rv1_%0d", k), rv1[k], m_l1[k]);
            chk($sformatf("rv2_%0d", k), rv2[k], m_l2[k]);
            chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_busy[k]));
        end
    endtask

    initial begin
        m_reset();
        #12;
        chk_reset();
        rst_n = 1'b1;
        we = 1'b1; wa = 5'd5; wv = 32'hDEADBEEF; cyc();
        we = 1'b0; re1 = 1'b1; ra1 = 5'd5; cyc();
        re1 = 1'b0; cyc();
        re1 = 1'b1; re2 = 1'b1;
        for (int i = 0; i < 32; i += 2) begin
            ra1 = 5'(i); ra2 = 5'(i + 1); cyc();
        end
        re1 = 1'b0; re2 = 1'b0;
        we = 1'b1; wa = 5'd10; wv = 32'h0A0A0A0A; cyc();
        wa = 5'd9; wv = 32'h12345678; re1 = 1'b1; re2 = 1'b1; ra1 = 5'd9; ra2 = 5'd9; cyc();
        wv = 32'h87654321; ra2 = 5'd10; cyc();
        wa = 5'd0; wv = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0; cyc();
        we = 1'b0; cyc();
        we = 1'b1; wa = 5'd30; wv = 32'hCAFEF00D; ra1 = 5'd30; ra2 = 5'd30; cyc();
        we = 1'b0; cyc();
        re1 = 1'b0; re2 = 1'b0; we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            wa = 5'(i); wv = 32'(i); cyc();
        end
        wa = 5'd3; wv = 32'h00000BAD; clr = 1'b1; cyc();
        we = 1'b0; clr = 1'b0; re1 = 1'b1; re2 = 1'b1;
        for (int i = 0; i < 34; i++) begin
            ra1 = 5'(i); ra2 = 5'($urandom_range(31)); clr = (i == 7); cyc();
        end
        clr = 1'b0;
        for (int i = 0; i < 32; i += 2) begin
            ra1 = 5'(i); ra2 = 5'(i + 1); cyc();
        end
        re1 = 1'b0; re2 = 1'b0; we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wa = 5'(i); wv = ~32'(i); cyc();
        end
        we = 1'b0; clr = 1'b1; cyc();
        clr = 1'b0; re1 = 1'b1; re2 = 1'b1; ra1 = 5'd4; ra2 = 5'd6;
        for (int i = 0; i < 10; i++) cyc();
        #2 rst_n = 1'b0;
        #1 chk_reset();
        m_reset();
        #1 rst_n = 1'b1;
        re1 = 1'b0; re2 = 1'b0; we = 1'b1; wa = 5'd20; wv = 32'h20202020; cyc();
        we = 1'b0; re1 = 1'b1; ra1 = 5'd20; cyc();
        for (int i = 0; i < 10000; i++) begin
            we  = 1'($urandom_range(1));
            wa  = 5'($urandom);
            wv  = $urandom;
            re1 = 1'($urandom_range(1));
            re2 = 1'($urandom_range(1));
            ra1 = ($urandom_range(3) == 0) ? wa : 5'($urandom);
            ra2 = 5'($urandom);
            clr = $urandom_range(63) == 0;
            cyc();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
